// File: rtl/core_periph_demux.sv
// Purpose: route one core request port to NB_SLAVES peripheral slaves by address window,
//          and answer out-of-window accesses with an error response one cycle after the grant.
// Latency: request, grant and slave responses pass through combinationally; decode errors respond 1 cycle after grant.
// Backpressure: core_gnt_o follows the target slave's grant. It is held low at MAX_OUTSTANDING, and while
//               draining toward a different target.
// Ports: clk_i/rst_i (sync, active-high); core_* request/response; slv_* flattened per-slave
//        buses (slave i occupies slice [i*W +: W]); outstanding_o count; spurious_rsp_o sticky flag.
module core_periph_demux #(
    parameter int                      NB_SLAVES       = 11,
    parameter int                      ADDR_WIDTH      = 32,
    parameter int                      DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR       = ADDR_WIDTH'(32'h1020_0000),
    parameter int                      REGION_BITS     = 10,
    parameter int                      MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0]   ERR_DATA        = DATA_WIDTH'(32'hBADC_AB1E)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              core_req_i,
    input  logic [ADDR_WIDTH-1:0]             core_add_i,
    input  logic                              core_wen_i,
    input  logic [DATA_WIDTH-1:0]             core_data_i,
    input  logic [DATA_WIDTH/8-1:0]           core_be_i,
    output logic                              core_gnt_o,
    output logic                              core_r_valid_o,
    output logic [DATA_WIDTH-1:0]             core_r_data_o,
    output logic                              core_r_err_o,
    output logic [NB_SLAVES-1:0]              slv_req_o,
    output logic [NB_SLAVES*ADDR_WIDTH-1:0]   slv_add_o,
    output logic [NB_SLAVES-1:0]              slv_wen_o,
    output logic [NB_SLAVES*DATA_WIDTH-1:0]   slv_data_o,
    output logic [NB_SLAVES*DATA_WIDTH/8-1:0] slv_be_o,
    input  logic [NB_SLAVES-1:0]              slv_gnt_i,
    input  logic [NB_SLAVES-1:0]              slv_r_valid_i,
    input  logic [NB_SLAVES*DATA_WIDTH-1:0]   slv_r_data_i,
    output logic [3:0]                        outstanding_o,
    output logic                              spurious_rsp_o
);

    localparam int IW = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
    localparam logic [3:0]            MAX_CNT = 4'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] NB_A    = ADDR_WIDTH'(NB_SLAVES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [IW-1:0]   tgt_idx;
    logic            tgt_err;   // locked target is the error pseudo-slave
    logic            err_pend;  // error request granted last cycle, answer now
    logic            spur;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] region;
    logic                  dec_err;
    logic [IW-1:0]         dec_idx;
    logic                  same_tgt;
    logic                  admit;
    logic                  fwd;
    logic                  sel_gnt;
    logic                  gnt;
    logic                  locked_ok;
    logic                  rsp_slv_vld;
    logic [DATA_WIDTH-1:0] rsp_slv_dat;
    logic                  rsp_slv;
    logic                  rsp;
    logic                  spur_evt;
    logic [3:0]            cnt_nxt;

    // Address decode
    assign offset  = core_add_i - BASE_ADDR;
    assign region  = offset >> REGION_BITS;
    assign dec_err = (core_add_i < BASE_ADDR) || (region >= NB_A);
    assign dec_idx = region[IW-1:0];

    // An error request matches an error lock; a slave request must hit the same index.
    assign same_tgt = tgt_err ? dec_err : (!dec_err && (dec_idx == tgt_idx));

    always_comb begin
        admit = 1'b0;
        case (state)
            S_IDLE:   admit = 1'b1;
            S_ACTIVE: admit = same_tgt && (cnt < MAX_CNT);
            default:  admit = 1'b0;
        endcase
    end

    assign fwd = core_req_i && admit && !rst_i;

    // A slave response is only genuine from the locked slave with something in flight.
    assign locked_ok = (state != S_IDLE) && !tgt_err && (cnt != 4'd0);

    always_comb begin
        sel_gnt     = 1'b0;
        rsp_slv_vld = 1'b0;
        rsp_slv_dat = '0;
        spur_evt    = 1'b0;
        slv_req_o   = '0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (dec_idx == IW'(i)) begin
                sel_gnt      = slv_gnt_i[i];
                slv_req_o[i] = fwd && !dec_err;
            end
            if (tgt_idx == IW'(i)) begin
                rsp_slv_vld = slv_r_valid_i[i];
                rsp_slv_dat = slv_r_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (slv_r_valid_i[i] && !(locked_ok && (tgt_idx == IW'(i))))
                spur_evt = 1'b1;
        end
    end

    // Decode errors are granted locally without involving any slave.
    assign gnt     = fwd && (dec_err || sel_gnt);
    assign rsp_slv = locked_ok && rsp_slv_vld;
    assign rsp     = !rst_i && (err_pend || rsp_slv);

    always_comb begin
        if (gnt && !rsp)
            cnt_nxt = cnt + 4'd1;
        else if (!gnt && rsp)
            cnt_nxt = cnt - 4'd1;
        else
            cnt_nxt = cnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            tgt_idx  <= '0;
            tgt_err  <= 1'b0;
            err_pend <= 1'b0;
            spur     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            err_pend <= gnt && dec_err;
            if (spur_evt)
                spur <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (gnt) begin
                        state   <= S_ACTIVE;
                        tgt_idx <= dec_err ? '0 : dec_idx;
                        tgt_err <= dec_err;
                    end
                end
                default: begin
                    // Emptying wins over a new drain request; the waiting request is admitted from IDLE.
                    if (cnt_nxt == 4'd0)
                        state <= S_IDLE;
                    else if ((state == S_ACTIVE) && core_req_i && !same_tgt)
                        state <= S_DRAIN;
                end
            endcase
        end
    end

    // Broadcast request payload; only slv_req_o selects the slave.
    assign slv_add_o  = {NB_SLAVES{core_add_i}};
    assign slv_wen_o  = {NB_SLAVES{core_wen_i}};
    assign slv_data_o = {NB_SLAVES{core_data_i}};
    assign slv_be_o   = {NB_SLAVES{core_be_i}};

    assign core_gnt_o     = gnt;
    assign core_r_valid_o = rsp;
    assign core_r_err_o   = !rst_i && err_pend;
    assign core_r_data_o  = rst_i    ? '0 :
                            err_pend ? ERR_DATA :
                            rsp_slv  ? rsp_slv_dat : '0;
    assign outstanding_o  = rst_i ? 4'd0 : cnt;
    assign spurious_rsp_o = !rst_i && spur;

endmodule

// File: tb/tb_core_periph_demux.sv
// Purpose: check core_periph_demux against a queue-based model of in-flight requests,
//          with directed scenarios followed by randomized traffic from emulated slaves.
// Latency/backpressure: inputs change 1 time unit after posedge, outputs sampled mid-cycle.
module tb_core_periph_demux;

    localparam int NB   = 11;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW/8;
    localparam int MAXO = 4;
    localparam logic [31:0] BASE = 32'h1020_0000;
    localparam logic [31:0] ERRD = 32'hBADC_AB1E;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 core_req_i = 1'b0;
    logic [AW-1:0]        core_add_i = '0;
    logic                 core_wen_i = 1'b0;
    logic [DW-1:0]        core_data_i = '0;
    logic [BW-1:0]        core_be_i = '0;
    logic                 core_gnt_o;
    logic                 core_r_valid_o;
    logic [DW-1:0]        core_r_data_o;
    logic                 core_r_err_o;
    logic [NB-1:0]        slv_req_o;
    logic [NB*AW-1:0]     slv_add_o;
    logic [NB-1:0]        slv_wen_o;
    logic [NB*DW-1:0]     slv_data_o;
    logic [NB*BW-1:0]     slv_be_o;
    logic [NB-1:0]        slv_gnt_i = '0;
    logic [NB-1:0]        slv_r_valid_i = '0;
    logic [NB*DW-1:0]     slv_r_data_i = '0;
    logic [3:0]           outstanding_o;
    logic                 spurious_rsp_o;

    always #5 clk = ~clk;

    core_periph_demux #(
        .NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .REGION_BITS(10), .MAX_OUTSTANDING(MAXO), .ERR_DATA(ERRD)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
        .core_data_i(core_data_i), .core_be_i(core_be_i), .core_gnt_o(core_gnt_o),
        .core_r_valid_o(core_r_valid_o), .core_r_data_o(core_r_data_o), .core_r_err_o(core_r_err_o),
        .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
        .slv_data_o(slv_data_o), .slv_be_o(slv_be_o), .slv_gnt_i(slv_gnt_i),
        .slv_r_valid_i(slv_r_valid_i), .slv_r_data_i(slv_r_data_i),
        .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
    );

    // Reference model: in-flight targets in grant order (-1 = decode error)
    int q[$];
    bit m_drain = 0;
    bit m_spur  = 0;
    int pend[NB];          // emulated slaves: requests each still has to answer
    int n_chk = 0;
    int n_err = 0;
    int last_idx = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE) return -1;
        off = (a - BASE) >> 10;
        if (off >= 32'(NB)) return -1;
        return int'(off);
    endfunction

    function automatic logic [31:0] slv_addr(input int idx);
        return BASE + (32'(idx) << 10) + 32'($urandom_range(0, 255) << 2);
    endfunction

    // Advance to just after the next rising edge and idle all inputs.
    task automatic next();
        @(posedge clk);
        #1;
        rst_i         = 1'b0;
        core_req_i    = 1'b0;
        core_wen_i    = 1'b0;
        slv_gnt_i     = '0;
        slv_r_valid_i = '0;
    endtask

    // Compare mid-cycle against the model, then advance the model past the coming edge.
    task automatic eval();
        int t;
        int old_head;
        bit rsp, rerr, admit, exp_gnt, spur_now, was_busy;
        logic [31:0] rdat;
        logic [NB-1:0] exp_req;
        int k;
        #4;
        t = decode(core_add_i);
        if (rst_i) begin
            chk("rst_gnt", core_gnt_o, 0);
            chk("rst_rvalid", core_r_valid_o, 0);
            chk("rst_rerr", core_r_err_o, 0);
            chk("rst_rdata", core_r_data_o, 0);
            chk("rst_slvreq", slv_req_o, 0);
            chk("rst_outst", outstanding_o, 0);
            q.delete();
            m_drain = 0;
            m_spur  = 0;
        end else begin
            rsp = 0; rerr = 0; rdat = '0;
            if (q.size() > 0) begin
                if (q[0] < 0) begin
                    rsp = 1; rerr = 1; rdat = ERRD;
                end else if (slv_r_valid_i[q[0]]) begin
                    rsp = 1; rdat = slv_r_data_i[q[0]*DW +: DW];
                end
            end
            admit   = (q.size() == 0) || (!m_drain && q[0] == t && q.size() < MAXO);
            exp_gnt = core_req_i && admit && (t < 0 || slv_gnt_i[t]);
            exp_req = '0;
            if (core_req_i && admit && t >= 0) exp_req[t] = 1'b1;
            chk("gnt", core_gnt_o, exp_gnt);
            chk("slv_req", slv_req_o, exp_req);
            chk("r_valid", core_r_valid_o, rsp);
            chk("r_err", core_r_err_o, rerr);
            if (rsp) chk("r_data", core_r_data_o, rdat);
            chk("outstanding", outstanding_o, q.size());
            chk("spurious", spurious_rsp_o, m_spur);
            k = $urandom_range(0, NB-1);
            chk("bcast_add", slv_add_o[k*AW +: AW], core_add_i);
            chk("bcast_data", {slv_wen_o[k], slv_be_o[k*BW +: BW], slv_data_o[k*DW +: DW]},
                {core_wen_i, core_be_i, core_data_i});

            spur_now = 0;
            for (int i = 0; i < NB; i++)
                if (slv_r_valid_i[i] && !(q.size() > 0 && q[0] == i)) spur_now = 1;
            was_busy = q.size() > 0;
            old_head = was_busy ? q[0] : -2;
            if (rsp) void'(q.pop_front());
            if (exp_gnt) q.push_back(t);
            if (q.size() == 0) m_drain = 0;
            else if (was_busy && !m_drain && core_req_i && t != old_head) m_drain = 1;
            if (spur_now) m_spur = 1;
            if (exp_gnt && t >= 0) pend[t]++;
        end
        for (int i = 0; i < NB; i++)
            if (slv_r_valid_i[i] && pend[i] > 0) pend[i]--;
    endtask

    task automatic do_reset();
        next(); rst_i = 1'b1; eval();
        next(); rst_i = 1'b1; eval();
    endtask

    task automatic rand_cycle();
        int r;
        int idx;
        next();
        rst_i       = ($urandom_range(0, 299) == 0);
        core_req_i  = ($urandom_range(0, 3) != 0);
        core_wen_i  = $urandom_range(0, 1) == 1;
        core_data_i = $urandom;
        core_be_i   = BW'($urandom);
        r = $urandom_range(0, 11);
        if (r < 5)       idx = last_idx;
        else if (r < 8)  idx = $urandom_range(0, 3);
        else if (r < 10) idx = $urandom_range(4, NB-1);
        else             idx = $urandom_range(NB, NB+4);
        if (r == 11 && $urandom_range(0, 1) == 1)
            core_add_i = BASE - 32'(4 + $urandom_range(0, 4095));
        else
            core_add_i = slv_addr(idx);
        last_idx      = idx;
        slv_gnt_i     = ~(NB'($urandom) & NB'($urandom));
        slv_r_data_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NB; i++)
            slv_r_valid_i[i] = (pend[i] > 0 && $urandom_range(0, 2) == 0) ||
                               ($urandom_range(0, 199) == 0);
        eval();
    endtask

    initial begin
        for (int i = 0; i < NB; i++) pend[i] = 0;
        do_reset();

        // Single read to slave 1, answered next cycle
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0400; slv_gnt_i[1] = 1; eval();
        chk("d32_gnt", core_gnt_o, 1);
        chk("d32_req", slv_req_o, 11'h002);
        next(); slv_r_valid_i[1] = 1; slv_r_data_i[1*DW +: DW] = 32'hCAFE_0001; eval();
        chk("d32_rdata", core_r_data_o, 32'hCAFE_0001);
        chk("d32_out1", outstanding_o, 1);
        next(); eval();
        chk("d32_out0", outstanding_o, 0);

        // Outstanding limit: five reads to slave 2, responses withheld
        for (int k = 0; k < 5; k++) begin
            next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0800; slv_gnt_i = '1; eval();
            chk("d33_gnt", core_gnt_o, (k < 4) ? 1 : 0);
        end
        chk("d33_out", outstanding_o, 4);
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0800; slv_gnt_i = '1;
        slv_r_valid_i[2] = 1; eval();
        chk("d33_full_rsp", core_gnt_o, 0);
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0800; slv_gnt_i = '1; eval();
        chk("d33_regrant", core_gnt_o, 1);
        for (int k = 0; k < 5; k++) begin
            next(); slv_r_valid_i[2] = (pend[2] > 0); eval();
        end
        next(); eval();
        chk("d33_empty", outstanding_o, 0);

        // Target switch must drain first
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = BASE; slv_gnt_i = '1; eval();
        for (int k = 0; k < 3; k++) begin
            next(); core_req_i = 1; core_wen_i = 1; core_add_i = BASE + 32'h0C00; slv_gnt_i = '1; eval();
            chk("d34_held", slv_req_o, 0);
        end
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = BASE + 32'h0C00; slv_gnt_i = '1;
        slv_r_valid_i[0] = 1; eval();
        chk("d34_rsp0", core_r_valid_o, 1);
        chk("d34_still_held", slv_req_o, 0);
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = BASE + 32'h0C00; slv_gnt_i = '1; eval();
        chk("d34_req3", slv_req_o, 11'h008);
        next(); slv_r_valid_i[3] = 1; eval();

        // Decode errors: above the last slave, and below the window (write)
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_3000; eval();
        chk("d35_gnt", core_gnt_o, 1);
        chk("d35_noreq", slv_req_o, 0);
        next(); eval();
        chk("d35_rvalid", core_r_valid_o, 1);
        chk("d35_rerr", core_r_err_o, 1);
        chk("d35_rdata", core_r_data_o, 32'hBADC_AB1E);
        next(); core_req_i = 1; core_wen_i = 0; core_add_i = 32'h0000_1000; eval();
        chk("d35w_gnt", core_gnt_o, 1);
        next(); eval();
        chk("d35w_rerr", core_r_err_o, 1);

        // Grant and response together hold the count; reset mid-flight
        for (int k = 0; k < 2; k++) begin
            next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0400; slv_gnt_i = '1; eval();
        end
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0400; slv_gnt_i = '1;
        slv_r_valid_i[1] = 1; eval();
        next(); core_req_i = 1; core_wen_i = 1; core_add_i = 32'h1020_0400; slv_gnt_i = '1; eval();
        chk("d36_hold2", outstanding_o, 2);
        next(); eval();
        chk("d36_out3", outstanding_o, 3);
        next(); rst_i = 1; eval();
        next(); eval();
        chk("d36_rst_out", outstanding_o, 0);
        chk("d36_no_spur", spurious_rsp_o, 0);
        next(); slv_r_valid_i[1] = 1; eval();
        chk("d36_drop", core_r_valid_o, 0);
        next(); eval();
        chk("d36_spur", spurious_rsp_o, 1);

        // Randomized traffic
        for (int i = 0; i < NB; i++) pend[i] = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
